// File: rtl/regfile_sb_if.sv
// Register-file bus: two read ports with busy flags, single-cycle write port A,
// late write port B and the busy-claim channel used by decode.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;
    logic              claim_en;
    logic [ADDR_W-1:0] claim_addr;
    logic              claim_ok;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W:0]   busy_cnt;
    logic              err_flag;

    modport master (
        output rd_addr1, rd_addr2, wa_en, wa_addr, wa_data,
               claim_en, claim_addr, wb_en, wb_addr, wb_data,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2,
               claim_ok, busy_cnt, err_flag
    );

    modport slave (
        input  rd_addr1, rd_addr2, wa_en, wa_addr, wa_data,
               claim_en, claim_addr, wb_en, wb_addr, wb_data,
        output rd_data1, rd_data2, rd_busy1, rd_busy2,
               claim_ok, busy_cnt, err_flag
    );
endinterface

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with optional hardwired zero register,
// write-to-read bypass and a per-register busy scoreboard for late writebacks.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_cnt;
    logic              r_err;

    logic [NREGS-1:0]  w_busy_next;
    logic [ADDR_W:0]   w_busy_cnt_next;
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];
    logic              w_rd_busy [2];
    logic              w_wa_zero;
    logic              w_wb_zero;
    logic              w_claim_zero;
    logic              w_ab_same;
    logic              w_claim_ok;
    logic              w_claim_set;
    logic              w_wb_clr;
    logic              w_wa_clr;
    logic              w_err_set;

    assign w_wa_zero    = ZERO_REG && (bus.wa_addr == '0);
    assign w_wb_zero    = ZERO_REG && (bus.wb_addr == '0);
    assign w_claim_zero = ZERO_REG && (bus.claim_addr == '0);
    assign w_ab_same    = bus.wa_en && bus.wb_en && (bus.wa_addr == bus.wb_addr);

    // A claim racing a same-cycle late write to the same index would lose WAW order.
    assign w_claim_ok  = bus.claim_en && !r_busy[bus.claim_addr]
                         && !(bus.wb_en && (bus.wb_addr == bus.claim_addr));
    assign w_claim_set = w_claim_ok && !w_claim_zero;
    assign w_wb_clr    = bus.wb_en && r_busy[bus.wb_addr];
    assign w_wa_clr    = bus.wa_en && r_busy[bus.wa_addr] && !w_ab_same;

    assign w_err_set = (bus.claim_en && !w_claim_ok)
                     || w_ab_same
                     || (bus.wa_en && r_busy[bus.wa_addr])
                     || (bus.wb_en && !r_busy[bus.wb_addr]);

    assign w_rd_addr[0] = bus.rd_addr1;
    assign w_rd_addr[1] = bus.rd_addr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
            w_rd_data[p] = r_regs[w_rd_addr[p]];
            if (BYPASS) begin
                if (bus.wa_en && (bus.wa_addr == w_rd_addr[p]))
                    w_rd_data[p] = bus.wa_data;
                else if (bus.wb_en && (bus.wb_addr == w_rd_addr[p]))
                    w_rd_data[p] = bus.wb_data;
            end
            if (ZERO_REG && (w_rd_addr[p] == '0))
                w_rd_data[p] = '0;
            w_rd_busy[p] = r_busy[w_rd_addr[p]]
                           && !(BYPASS && bus.wb_en && (bus.wb_addr == w_rd_addr[p]));
        end
    end

    always_comb begin
        w_busy_next = r_busy;
        if (bus.wb_en)
            w_busy_next[bus.wb_addr] = 1'b0;
        if (bus.wa_en)
            w_busy_next[bus.wa_addr] = 1'b0;
        if (w_claim_set)
            w_busy_next[bus.claim_addr] = 1'b1;
        w_busy_cnt_next = r_busy_cnt + (ADDR_W+1)'(w_claim_set)
                          - (ADDR_W+1)'(w_wb_clr) - (ADDR_W+1)'(w_wa_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is flops with an architectural reset value, so it is reset like any other state.
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            if (bus.wb_en && !w_wb_zero)
                r_regs[bus.wb_addr] <= bus.wb_data;
            // NOTE: non-blocking, and the later assignment wins, so port A overrides port B on the same index.
            if (bus.wa_en && !w_wa_zero)
                r_regs[bus.wa_addr] <= bus.wa_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_busy     <= w_busy_next;
            r_busy_cnt <= w_busy_cnt_next;
            r_err      <= r_err || w_err_set;
        end
    end

    assign bus.rd_data1 = w_rd_data[0];
    assign bus.rd_data2 = w_rd_data[1];
    assign bus.rd_busy1 = w_rd_busy[0];
    assign bus.rd_busy2 = w_rd_busy[1];
    assign bus.claim_ok = w_claim_ok;
    assign bus.busy_cnt = r_busy_cnt;
    assign bus.err_flag = r_err;
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write-port CPU register file.
- Two combinational read ports and two write ports:
  - Port A: normal single-cycle writeback.
  - Port B: late writeback from multi-cycle units (loads, mul/div).
- Adds hardwired-zero register, write-to-read bypass, and a per-register busy scoreboard so decode can stall on RAW hazards against outstanding long-latency results.
- Sits between decode (reads, claims) and the writeback stages.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth NREGS = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, and can never be claimed busy.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored array contents only.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr1  in  ADDR_W  read port 1 index.
- rd_addr2  in  ADDR_W  read port 2 index.
- rd_data1  out  DATA_W  read port 1 data (combinational).
- rd_data2  out  DATA_W  read port 2 data (combinational).
- rd_busy1  out  1  register at rd_addr1 has an outstanding late write.
- rd_busy2  out  1  register at rd_addr2 has an outstanding late write.
- wa_en  in  1  port A write enable.
- wa_addr  in  ADDR_W  port A index.
- wa_data  in  DATA_W  port A data.
- claim_en  in  1  mark claim_addr busy (late-write op issued).
- claim_addr  in  ADDR_W  index to mark busy.
- claim_ok  out  1  claim accepted this cycle (combinational).
- wb_en  in  1  port B (late) write enable.
- wb_addr  in  ADDR_W  port B index.
- wb_data  in  DATA_W  port B data.
- busy_cnt  out  ADDR_W+1  number of busy registers (registered).
- err_flag  out  1  sticky protocol error.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All NREGS registers = 0.
  - All busy bits = 0.
  - busy_cnt = 0.
  - err_flag = 0.
  - Reset mid-operation discards all outstanding claims; any later wb_en to a non-busy register then sets err_flag.
- Writes occur on the rising clk edge.
  - Port A and port B to different addresses: both written.
  - Same address with both enabled: port A data stored (younger instruction wins), busy bit still cleared, err_flag set.
- ZERO_REG=1:
  - Writes to index 0 ignored.
  - rd_data of index 0 = 0 regardless of bypass.
  - Claim of 0 is accepted with no busy effect.
- Read, BYPASS=1, priority order:
  - wa_en and wa_addr match -> wa_data.
  - Else wb_en and wb_addr match -> wb_data.
  - Else array contents.
- Read, BYPASS=0: array contents only; newly written value visible the cycle after the write.
- rd_busyN = busy[rd_addrN] AND NOT (wb_en AND wb_addr == rd_addrN AND BYPASS).
  - With BYPASS=0, drop the wb term: busy is visible until the clearing edge.
- claim_ok = claim_en AND NOT busy[claim_addr] AND NOT (wb_en AND wb_addr == claim_addr).
  - A claim hitting a busy register is rejected (claim_ok=0), has no state change, and sets err_flag.
  - A claim colliding with a same-cycle wb to the same index is also rejected (WAW ordering) and sets err_flag.
- Busy update per edge:
  - Set on an accepted claim.
  - Cleared on wb_en to that index.
  - Also cleared by wa_en to a busy index; this additionally sets err_flag (the late result would be overwritten out of order).
- wb_en to a non-busy register: data still written, err_flag set.
- busy_cnt next = busy_cnt + (accepted claim, non-zero-reg) − (wb clearing a busy bit) − (wa clearing a busy bit, distinct index).
  - Set and clear in the same cycle net to 0.
  - Range 0..NREGS, never wraps.
  - Equals popcount(busy) at every edge.
- err_flag is sticky until reset.

Test Plan:
- Reset then read all 32 indices -> every rd_data = 0x00000000, rd_busy = 0, busy_cnt = 0, err_flag = 0.
- wa_en, wa_addr=5, wa_data=0xDEADBEEF; same cycle rd_addr1=5 -> rd_data1 = 0xDEADBEEF (BYPASS=1); next cycle still 0xDEADBEEF. With BYPASS=0, same cycle = 0, next cycle = 0xDEADBEEF.
- Write 0x1234 to index 0 -> rd_data of index 0 = 0; claim index 0 -> claim_ok = 1, busy_cnt stays 0.
- claim_addr=7 -> claim_ok = 1, busy_cnt = 1, rd_busy1 (rd_addr1=7) = 1. Three cycles later wb_en, wb_addr=7, wb_data=0xCAFE0001 -> same cycle rd_busy1 = 0, rd_data1 = 0xCAFE0001; next cycle busy_cnt = 0.
- Second claim of 7 while busy -> claim_ok = 0, err_flag = 1, busy_cnt unchanged.
- Same-cycle wa_en and wb_en both to index 9 (wa_data=0xA, wb_data=0xB) -> reg9 = 0xA, err_flag = 1.
- Claim 31 regs (1..31) -> busy_cnt = 31. Assert rst_n low mid-cycle -> immediately busy_cnt = 0 and all rd_busy = 0.
